// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-group PC generator with branch/exception redirect.
// Keeps a registered base PC, presents ISSUE_W consecutive slot PCs, and
// issues a one-cycle decode flush mask on partial issue or redirect.
// Optional feature macro: FETCH_PC_EXC_EN adds the exc_req port, which
// redirects to EXC_VECTOR and overrides a simultaneous branch_taken.
module fetch_pc_ctrl #(
   parameter int                 WIDTH    = 32,
   parameter int                 ISSUE_W  = 2,
   parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000
`ifdef FETCH_PC_EXC_EN
  ,parameter logic [WIDTH-1:0]   EXC_VECTOR = 32'h0000_0380
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [$clog2(ISSUE_W+1)-1:0] issue_cnt,
   input  logic                       branch_taken,
   input  logic [WIDTH-1:0]           branch_address,
`ifdef FETCH_PC_EXC_EN
   input  logic                       exc_req,
`endif
   output logic [ISSUE_W*WIDTH-1:0]   pc_group,
   output logic [ISSUE_W-1:0]         flush_mask,
   output logic                       redirect,
   output logic                       addr_err
);

   localparam int CNT_W = $clog2(ISSUE_W+1);

   typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

   // Clamp an out-of-range issue count to a full group.
   function automatic logic [CNT_W-1:0] sat_issue(input logic [CNT_W-1:0] cnt);
      if (cnt > CNT_W'(ISSUE_W)) return CNT_W'(ISSUE_W);
      return cnt;
   endfunction

   // Flush every slot at or beyond the first unissued one; nothing on 0 or full issue.
   function automatic logic [ISSUE_W-1:0] tail_mask(input logic [CNT_W-1:0] k);
      logic [ISSUE_W-1:0] m;
      m = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         m[i] = (k != '0) && (CNT_W'(i) >= k);
      end
      return m;
   endfunction

   logic [WIDTH-1:0]   pc_base_p0, pc_base_p1;
   logic [ISSUE_W-1:0] flush_p0, flush_p1;
   logic               err_p0, err_p1;
   state_t             state_p0, state_p1;
   logic [CNT_W-1:0]   k_p0;

   // Next-state, next-PC and pulse outputs; priority exc_req > branch_taken > en.
   always_comb begin
      k_p0       = sat_issue(issue_cnt);
      pc_base_p0 = pc_base_p1;
      flush_p0   = '0;
      err_p0     = 1'b0;
      state_p0   = state_p1;
`ifdef FETCH_PC_EXC_EN
      if (exc_req) begin
         pc_base_p0 = EXC_VECTOR;
         flush_p0   = '1;
         state_p0   = REDIRECT;
      end else
`endif
      if (branch_taken) begin
         pc_base_p0 = {branch_address[WIDTH-1:2], 2'b00};
         flush_p0   = '1;
         err_p0     = |branch_address[1:0];
         state_p0   = REDIRECT;
      end else if (en) begin
         if (state_p1 == REDIRECT) begin
            // The first enabled cycle after a redirect only drains the bubble.
            state_p0 = RUN;
         end else begin
            pc_base_p0 = pc_base_p1 + (WIDTH'(k_p0) << 2);
            flush_p0   = tail_mask(k_p0);
         end
      end
   end

   // Registered PC, flush pulse, error pulse and controller state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_base_p1 <= RESET_PC;
         flush_p1   <= '0;
         err_p1     <= 1'b0;
         state_p1   <= RUN;
      end else begin
         pc_base_p1 <= pc_base_p0;
         flush_p1   <= flush_p0;
         err_p1     <= err_p0;
         state_p1   <= state_p0;
      end
   end

   for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
      assign pc_group[g*WIDTH +: WIDTH] = pc_base_p1 + WIDTH'(4*g);
   end

   assign flush_mask = flush_p1;
   assign redirect   = (state_p1 == REDIRECT);
   assign addr_err   = err_p1;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: scoreboard bench for fetch_pc_ctrl with a 2-wide and a
// 4-wide instance. Stimulus pushes hand-computed expectations; a monitor
// pops and compares them shortly after each rising edge.
module tb_fetch_pc_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic        en_a = 1'b0, bt_a = 1'b0;
   logic [1:0]  cnt_a = '0;
   logic [31:0] ba_a = '0;
   logic [63:0] pcg_a;
   logic [1:0]  fl_a;
   logic        rd_a, er_a;

   logic        en_b = 1'b0, bt_b = 1'b0;
   logic [2:0]  cnt_b = '0;
   logic [31:0] ba_b = '0;
   logic [127:0] pcg_b;
   logic [3:0]  fl_b;
   logic        rd_b, er_b;
`ifdef FETCH_PC_EXC_EN
   logic        exc_a = 1'b0, exc_b = 1'b0;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          inst;
      logic [31:0] pc;
      logic [3:0]  fl;
      logic        rd;
      logic        err;
      string       name;
   } exp_t;

   exp_t q[$];
   event mon_ev;

   fetch_pc_ctrl #(.WIDTH(32), .ISSUE_W(2)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .issue_cnt(cnt_a),
      .branch_taken(bt_a), .branch_address(ba_a),
`ifdef FETCH_PC_EXC_EN
      .exc_req(exc_a),
`endif
      .pc_group(pcg_a), .flush_mask(fl_a), .redirect(rd_a), .addr_err(er_a)
   );

   fetch_pc_ctrl #(.WIDTH(32), .ISSUE_W(4)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .issue_cnt(cnt_b),
      .branch_taken(bt_b), .branch_address(ba_b),
`ifdef FETCH_PC_EXC_EN
      .exc_req(exc_b),
`endif
      .pc_group(pcg_b), .flush_mask(fl_b), .redirect(rd_b), .addr_err(er_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      ->mon_ev;
   end

   function automatic void push(input int inst, input logic [31:0] pc, input logic [3:0] fl,
                                input logic rd, input logic err, input string nm);
      exp_t e;
      e.inst = inst; e.pc = pc; e.fl = fl; e.rd = rd; e.err = err; e.name = nm;
      q.push_back(e);
   endfunction

   task automatic check(input exp_t e);
      logic        bad;
      logic [31:0] act_pc;
      logic [3:0]  act_fl;
      logic        act_rd, act_er;
      bad = 1'b0;
      if (e.inst == 0) begin
         for (int s = 0; s < 2; s++)
            if (pcg_a[s*32 +: 32] !== e.pc + 32'(4*s)) bad = 1'b1;
         act_pc = pcg_a[31:0]; act_fl = {2'b00, fl_a}; act_rd = rd_a; act_er = er_a;
      end else begin
         for (int s = 0; s < 4; s++)
            if (pcg_b[s*32 +: 32] !== e.pc + 32'(4*s)) bad = 1'b1;
         act_pc = pcg_b[31:0]; act_fl = fl_b; act_rd = rd_b; act_er = er_b;
      end
      if (act_fl !== e.fl || act_rd !== e.rd || act_er !== e.err) bad = 1'b1;
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL %s: got pc=%h flush=%b redirect=%b addr_err=%b, want pc=%h flush=%b redirect=%b addr_err=%b (all slots pc+4*i)",
                  e.name, act_pc, act_fl, act_rd, act_er, e.pc, e.fl, e.rd, e.err);
      end
   endtask

   // Monitor: drain and compare all expectations due at this sample point.
   initial begin
      forever begin
         @(mon_ev);
         while (q.size() > 0) check(q.pop_front());
      end
   end

   task automatic step_a(input logic en, input logic [1:0] cnt, input logic bt, input logic [31:0] ba,
                         input logic [31:0] pc, input logic [1:0] fl, input logic rd, input logic err,
                         input string nm);
      @(negedge clk);
      en_a = en; cnt_a = cnt; bt_a = bt; ba_a = ba;
      push(0, pc, {2'b00, fl}, rd, err, nm);
   endtask

   task automatic step_b(input logic en, input logic [2:0] cnt, input logic bt, input logic [31:0] ba,
                         input logic [31:0] pc, input logic [3:0] fl, input logic rd, input logic err,
                         input string nm);
      @(negedge clk);
`ifdef FETCH_PC_EXC_EN
      exc_b = 1'b0;
`endif
      en_b = en; cnt_b = cnt; bt_b = bt; ba_b = ba;
      push(1, pc, fl, rd, err, nm);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset dominates active inputs
      @(negedge clk);
      en_a = 1'b1; cnt_a = 2'd2;
      push(0, 32'h0, 4'h0, 1'b0, 1'b0, "reset_a");
      push(1, 32'h0, 4'h0, 1'b0, 1'b0, "reset_b");
      @(negedge clk);
      rst = 1'b0; en_a = 1'b0;

      // 2-wide instance
      step_a(1, 2'd2, 0, 32'h0,         32'h0000_0008, 2'b00, 0, 0, "a_full_1");
      step_a(1, 2'd2, 0, 32'h0,         32'h0000_0010, 2'b00, 0, 0, "a_full_2");
      step_a(1, 2'd2, 0, 32'h0,         32'h0000_0018, 2'b00, 0, 0, "a_full_3");
      step_a(1, 2'd1, 0, 32'h0,         32'h0000_001C, 2'b10, 0, 0, "a_partial_1");
      step_a(1, 2'd0, 0, 32'h0,         32'h0000_001C, 2'b00, 0, 0, "a_zero_issue");
      step_a(1, 2'd3, 0, 32'h0,         32'h0000_0024, 2'b00, 0, 0, "a_sat_issue");
      step_a(0, 2'd2, 0, 32'h0,         32'h0000_0024, 2'b00, 0, 0, "a_stall");
      step_a(0, 2'd2, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 2'b11, 1, 1, "a_misaligned_branch");
      step_a(0, 2'd2, 0, 32'h0,         32'hFFFF_FFFC, 2'b00, 1, 0, "a_redirect_stall");
      step_a(1, 2'd2, 0, 32'h0,         32'hFFFF_FFFC, 2'b00, 0, 0, "a_redirect_drain");
      step_a(1, 2'd2, 0, 32'h0,         32'h0000_0004, 2'b00, 0, 0, "a_wrap");
      step_a(1, 2'd2, 1, 32'h0000_0100, 32'h0000_0100, 2'b11, 1, 0, "a_branch_en");
      step_a(1, 2'd2, 1, 32'h0000_0200, 32'h0000_0200, 2'b11, 1, 0, "a_rebranch");
      step_a(1, 2'd1, 0, 32'h0,         32'h0000_0200, 2'b00, 0, 0, "a_drain_2");
      @(negedge clk);
      en_a = 1'b0; bt_a = 1'b0;

      // 4-wide instance
      step_b(0, 3'd0, 1, 32'h0000_0100, 32'h0000_0100, 4'b1111, 1, 0, "b_branch_100");
      step_b(1, 3'd3, 0, 32'h0,         32'h0000_0100, 4'b0000, 0, 0, "b_drain");
      step_b(1, 3'd1, 0, 32'h0,         32'h0000_0104, 4'b1110, 0, 0, "b_issue1");
      step_b(1, 3'd3, 0, 32'h0,         32'h0000_0110, 4'b1000, 0, 0, "b_issue3");
      step_b(1, 3'd2, 0, 32'h0,         32'h0000_0118, 4'b1100, 0, 0, "b_issue2");
      step_b(1, 3'd4, 0, 32'h0,         32'h0000_0128, 4'b0000, 0, 0, "b_issue4");
      step_b(1, 3'd7, 0, 32'h0,         32'h0000_0138, 4'b0000, 0, 0, "b_sat_issue");
      step_b(0, 3'd2, 0, 32'h0,         32'h0000_0138, 4'b0000, 0, 0, "b_stall");
      step_b(0, 3'd2, 1, 32'h0000_2002, 32'h0000_2000, 4'b1111, 1, 1, "b_misaligned_branch");
      step_b(1, 3'd2, 0, 32'h0,         32'h0000_2000, 4'b0000, 0, 0, "b_redirect_drain");
      step_b(1, 3'd2, 0, 32'h0,         32'h0000_2008, 4'b1100, 0, 0, "b_after_drain");
`ifdef FETCH_PC_EXC_EN
      @(negedge clk);
      exc_b = 1'b1; en_b = 1'b0; bt_b = 1'b1; ba_b = 32'h0000_1003;
      push(1, 32'h0000_0380, 4'b1111, 1'b1, 1'b0, "b_exc_over_branch");
`endif
      step_b(1, 3'd2, 1, 32'h0000_0400, 32'h0000_0400, 4'b1111, 1, 0, "b_branch_400");

      // Asynchronous reset between edges while in REDIRECT
      @(posedge clk);
      #3;
      rst = 1'b1;
      push(0, 32'h0, 4'h0, 1'b0, 1'b0, "a_async_reset");
      push(1, 32'h0, 4'h0, 1'b0, 1'b0, "b_async_reset");
      #1;
      ->mon_ev;

      // First edge after reset release evaluates inputs
      @(negedge clk);
      rst = 1'b0; en_b = 1'b1; cnt_b = 3'd4; bt_b = 1'b0;
      push(1, 32'h0000_0010, 4'b0000, 1'b0, 1'b0, "b_first_edge_after_reset");
      @(negedge clk);
      en_b = 1'b0;

      repeat (3) @(posedge clk);
      #4;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: PC and address width in bits.
REQ-002 Parameter ISSUE_W, default 2: fetch group size in instructions; legal range 1..4.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: base PC after reset.
REQ-004 Parameter EXC_VECTOR, default 32'h0000_0380: exception redirect target.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port en, input, 1 bit: advance enable; 0 = pipeline stall.
REQ-008 Port issue_cnt, input, $clog2(ISSUE_W+1) bits: number of in-order slots of the current group issued this cycle.
REQ-009 Port branch_taken, input, 1 bit: redirect request.
REQ-010 Port branch_address, input, WIDTH bits: redirect target.
REQ-011 Port exc_req, input, 1 bit: exception redirect; present only with the configuration macro.
REQ-012 Port pc_group, output, ISSUE_W*WIDTH bits: slot i occupies bits [i*WIDTH +: WIDTH] and equals pc_base + 4*i.
REQ-013 Port flush_mask, output, ISSUE_W bits: one-cycle pulse; bit i set flushes decode slot i.
REQ-014 Port redirect, output, 1 bit: high while the controller is in state REDIRECT.
REQ-015 Port addr_err, output, 1 bit: one-cycle pulse for a misaligned redirect target.

Function
REQ-016 pc_base, flush_mask, state, redirect and addr_err shall all be registered; an input in cycle t shall take effect on outputs in cycle t+1.
REQ-017 There shall be two states, RUN and REDIRECT, leaving reset in RUN.
REQ-018 Event priority each cycle shall be: rst, then exc_req, then branch_taken, then en/issue_cnt.
REQ-019 On branch_taken, regardless of en, pc_base shall load {branch_address[WIDTH-1:2],2'b00}, flush_mask shall be all ones, and state shall go to REDIRECT.
REQ-020 When branch_address[1:0] != 0 on a redirect, addr_err shall pulse for one cycle; the aligned target is still used.
REQ-021 In RUN with en=1 and issue_cnt=k, where 0<k<ISSUE_W: pc_base += 4*k, and flush_mask bits k..ISSUE_W-1 shall be set, all others clear.
REQ-022 In RUN with en=1 and k=ISSUE_W: pc_base += 4*ISSUE_W and flush_mask shall be 0.
REQ-023 In RUN with en=1 and k=0: pc_base shall hold and flush_mask shall be 0.
REQ-024 Any issue_cnt > ISSUE_W shall be treated as ISSUE_W.
REQ-025 With en=0 and no redirect: pc_base and state shall hold, and flush_mask shall be 0.
REQ-026 In REDIRECT, issue_cnt shall be ignored for exactly one cycle: pc_base shall hold, the state shall return to RUN, and flush_mask shall be 0; the hold applies only when en=1, and with en=0 the state remains REDIRECT.
REQ-027 A branch_taken arriving in REDIRECT shall re-redirect per REQ-019 and remain in REDIRECT.
REQ-028 PC arithmetic shall be modulo 2^WIDTH, so 32'hFFFF_FFFC + 8 gives 32'h0000_0004 with no error.

Reset
REQ-029 While rst=1, asynchronously: pc_base=RESET_PC, state=RUN, and flush_mask, redirect and addr_err all 0.
REQ-030 Reset asserted mid-operation, including in REDIRECT, shall abandon any pending redirect.
REQ-031 After rst deasserts, the first edge shall evaluate inputs normally.

Configuration
REQ-032 Macro FETCH_PC_EXC_EN: when defined, the exc_req port shall exist, and exc_req=1 shall load pc_base=EXC_VECTOR, set flush_mask to all ones, enter REDIRECT, and override a simultaneous branch_taken.
REQ-033 When FETCH_PC_EXC_EN is undefined, there shall be no exc_req port, no EXC_VECTOR use, and all other behaviour shall be unchanged.

Verification
REQ-034 Scenario: ISSUE_W=2, reset, en=1, issue_cnt=2 for 3 cycles -> slot 0 = 0x0, 0x8, 0x10, 0x18; slot 1 = slot 0 + 4; flush_mask=0.
REQ-035 Scenario: ISSUE_W=4, base 0x100, issue_cnt=1 -> base 0x104 and flush_mask=4'b1110 for one cycle; then issue_cnt=3 -> base 0x110 and flush_mask=4'b1000.
REQ-036 Scenario: branch_taken with branch_address=0x2002 and en=0 -> base 0x2000, flush_mask all ones, addr_err=1, redirect=1; next cycle with en=1 and issue_cnt=2 -> base stays 0x2000 and state returns to RUN.
REQ-037 Scenario: base 0xFFFF_FFFC, ISSUE_W=2, issue_cnt=2 -> base 0x0000_0004.
REQ-038 Scenario: rst asserted asynchronously between edges while in REDIRECT -> outputs show RESET_PC, flush_mask=0 and redirect=0 before the next edge.
REQ-039 Scenario: with FETCH_PC_EXC_EN defined, exc_req and branch_taken asserted together -> base EXC_VECTOR (0x380) and flush_mask all ones.
